// File: rtl/i2s_tx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2s_tx_ctrl                                                   |
// | Purpose  : Stereo I2S transmitter; MCLK/SCLK/LRCK/SDATA from one phase    |
// |            counter, left/right pairs taken over a valid/ready handshake. |
// | Option   : I2S_TX_HOLD_LAST_EN - replay the last pair on an underrun.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module i2s_tx_ctrl #(
    parameter int MCLK_HALF = 4,
    parameter int SCLK_DIV  = 4,
    parameter int SAMPLE_W  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                mclk,
    output logic                sclk,
    output logic                lrck,
    output logic                sdata,
    output logic                frame_start,
    output logic                underrun
);

    localparam int         c_MCLK_BIT  = $clog2(MCLK_HALF);
    localparam int         c_SCLK_BIT  = $clog2(MCLK_HALF * SCLK_DIV);
    localparam int         c_P_W       = c_SCLK_BIT + 7;
    localparam logic [4:0] c_LAST_SLOT = 5'(SAMPLE_W);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_P_W-1:0]    r_p;
    logic                r_alive;
    logic                r_full;
    logic [SAMPLE_W-1:0] r_hold_l;
    logic [SAMPLE_W-1:0] r_hold_r;
    logic [SAMPLE_W-1:0] r_sh_l;
    logic [SAMPLE_W-1:0] r_sh_r;
    logic                r_mclk;
    logic                r_sclk;
    logic                r_lrck;
    logic                r_sdata;
    logic                r_frame_start;
    logic                r_underrun;

    logic                w_boundary;
    logic                w_slot_start;
    logic                w_right_half;
    logic [4:0]          w_k;
    logic                w_bit_slot;
    logic                w_accept;
    logic                w_load_pair;
    logic                w_underrun;
    logic [SAMPLE_W-1:0] w_fill_l;
    logic [SAMPLE_W-1:0] w_fill_r;

    // Slot index within the half-frame sits directly above the SCLK bit.
    assign w_boundary   = (r_p == '0);
    assign w_slot_start = (r_p[c_SCLK_BIT:0] == '0);
    assign w_right_half = r_p[c_P_W-1];
    assign w_k          = r_p[c_P_W-2:c_SCLK_BIT+1];
    assign w_bit_slot   = (w_k != 5'd0) && (w_k <= c_LAST_SLOT);
    assign w_accept     = s_valid && s_ready;

    assign s_ready      = r_alive && !r_full;
    assign mclk         = r_mclk;
    assign sclk         = r_sclk;
    assign lrck         = r_lrck;
    assign sdata        = r_sdata;
    assign frame_start  = r_frame_start;
    assign underrun     = r_underrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_pair = 1'b0;
        w_underrun  = 1'b0;
        if (w_boundary) begin
            case (r_state)
                ST_WAIT: begin
                    if (en && r_full) begin
                        w_load_pair = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        w_state_nxt = ST_WAIT;
                    end else if (r_full) begin
                        w_load_pair = 1'b1;
                    end else begin
                        w_underrun = 1'b1;
                    end
                end
                default: w_state_nxt = ST_WAIT;
            endcase
        end
    end

`ifdef I2S_TX_HOLD_LAST_EN
    logic [SAMPLE_W-1:0] r_last_l;
    logic [SAMPLE_W-1:0] r_last_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_l <= '0;
            r_last_r <= '0;
        end else if (w_load_pair) begin
            r_last_l <= r_hold_l;
            r_last_r <= r_hold_r;
        end
    end

    assign w_fill_l = w_load_pair ? r_hold_l : (w_underrun ? r_last_l : '0);
    assign w_fill_r = w_load_pair ? r_hold_r : (w_underrun ? r_last_r : '0);
`else
    assign w_fill_l = w_load_pair ? r_hold_l : '0;
    assign w_fill_r = w_load_pair ? r_hold_r : '0;
`endif

    // A boundary load and a fresh accept never coincide: accept needs full=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alive  <= 1'b0;
            r_full   <= 1'b0;
            r_hold_l <= '0;
            r_hold_r <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_full   <= 1'b1;
                r_hold_l <= s_left;
                r_hold_r <= s_right;
            end else if (w_load_pair) begin
                r_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p           <= '0;
            r_mclk        <= 1'b0;
            r_sclk        <= 1'b0;
            r_lrck        <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_p           <= r_p + 1'b1;
            r_mclk        <= r_p[c_MCLK_BIT];
            r_sclk        <= r_p[c_SCLK_BIT];
            r_lrck        <= w_right_half;
            r_frame_start <= w_boundary;
            r_underrun    <= w_underrun;
        end
    end

    // Bits leave MSB-first, one per SCLK period, starting one slot after LRCK.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_l  <= '0;
            r_sh_r  <= '0;
            r_sdata <= 1'b0;
        end else if (w_boundary) begin
            r_sh_l  <= w_fill_l;
            r_sh_r  <= w_fill_r;
            r_sdata <= 1'b0;
        end else if (w_slot_start) begin
            if (!w_bit_slot) begin
                r_sdata <= 1'b0;
            end else if (w_right_half) begin
                r_sdata <= r_sh_r[SAMPLE_W-1];
                r_sh_r  <= r_sh_r << 1;
            end else begin
                r_sdata <= r_sh_l[SAMPLE_W-1];
                r_sh_l  <= r_sh_l << 1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_i2s_tx_ctrl                                                |
// | Purpose  : Self-checking bench for i2s_tx_ctrl at default parameters.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_i2s_tx_ctrl;

    localparam int MH = 4;
    localparam int SH = 16;
    localparam int FR = 2048;
    localparam int W  = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_left = '0;
    logic [W-1:0] s_right = '0;
    logic         mclk, sclk, lrck, sdata, frame_start, underrun;

    always #5 clk = ~clk;

    i2s_tx_ctrl #(.MCLK_HALF(4), .SCLK_DIV(4), .SAMPLE_W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .mclk(mclk), .sclk(sclk),
        .lrck(lrck), .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] pat(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    // Reference model: one step per clock, outputs computed from phase arithmetic.
    int           m_p = 0;
    bit           m_full, m_alive, m_run;
    logic [W-1:0] m_hl, m_hr, m_fl, m_fr;
`ifdef I2S_TX_HOLD_LAST_EN
    logic [W-1:0] m_ll, m_lr;
`endif
    logic [6:0]   exp_v;

    always @(posedge clk) begin
        int q, b, k;
        bit acc, ur;
        logic [W-1:0] word;
        if (rst) begin
            m_p = 0; m_full = 0; m_alive = 0; m_run = 0;
            m_fl = '0; m_fr = '0; exp_v = '0;
`ifdef I2S_TX_HOLD_LAST_EN
            m_ll = '0; m_lr = '0;
`endif
        end else begin
            q   = m_p;
            acc = s_valid && m_alive && !m_full;
            ur  = 0;
            if (q == 0) begin
                if (en && m_full) begin
                    m_fl = m_hl; m_fr = m_hr; m_full = 0; m_run = 1;
`ifdef I2S_TX_HOLD_LAST_EN
                    m_ll = m_hl; m_lr = m_hr;
`endif
                end else if (m_run && en) begin
                    ur = 1;
`ifdef I2S_TX_HOLD_LAST_EN
                    m_fl = m_ll; m_fr = m_lr;
`else
                    m_fl = '0; m_fr = '0;
`endif
                end else begin
                    m_fl = '0; m_fr = '0; m_run = 0;
                end
            end
            if (acc) begin
                m_hl = s_left; m_hr = s_right; m_full = 1;
            end
            m_alive = 1;
            b    = q / (2 * SH);
            k    = b % 32;
            word = (b >= 32) ? m_fr : m_fl;
            exp_v = {1'((q / MH) % 2), 1'((q / SH) % 2), 1'(b >= 32),
                     (k >= 1 && k <= W) ? word[W-k] : 1'b0,
                     1'(q == 0), ur, 1'(m_alive && !m_full)};
            m_p = (q + 1) % FR;
        end
        #1;
        check("outputs{mclk,sclk,lrck,sdata,fs,ur,rdy}",
              {57'd0, mclk, sclk, lrck, sdata, frame_start, underrun, s_ready}, {57'd0, exp_v});
    end

    // Frame recorder: sdata at SCLK rises, underrun pulses and s_ready rises per frame.
    int          frame_no = 0;
    logic [63:0] cur_bits;
    logic [63:0] fbits [0:15];
    int          cur_ur, cur_rr;
    int          fur [0:15];
    int          frr [0:15];
    logic        prev_sclk, prev_rdy;

    always @(posedge clk) begin
        #2;
        if (rst) begin
            frame_no = 0; cur_bits = '0; cur_ur = 0; cur_rr = 0;
            prev_sclk = 1'b0; prev_rdy = 1'b0;
        end else begin
            if (frame_start) begin
                if (frame_no >= 1 && frame_no <= 15) begin
                    fbits[frame_no] = cur_bits; fur[frame_no] = cur_ur; frr[frame_no] = cur_rr;
                end
                frame_no++;
                cur_bits = '0; cur_ur = 0; cur_rr = 0;
            end
            if (underrun) cur_ur++;
            if (sclk && !prev_sclk) cur_bits = {cur_bits[62:0], sdata};
            if (s_ready && !prev_rdy) cur_rr++;
            prev_sclk = sclk;
            prev_rdy  = s_ready;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frame_no < n && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("frame_reached", 64'(frame_no >= n), 64'd1);
    endtask

    task automatic wait_p(input int v);
        int t = 0;
        while (m_p != v && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("phase_reached", 64'(m_p), 64'(v));
    endtask

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        int t = 0;
        s_valid = 1'b1; s_left = l; s_right = r;
        while (!s_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("send_accept", 64'(s_ready), 64'd1);
        @(negedge clk);
        s_valid = 1'b0; s_left = ~l; s_right = ~r;
    endtask

    initial begin
        int mr, sr, lr, fs, lh, tgt, t;
        logic pm, ps, pl;
        logic [W-1:0] v;
        logic rdy;

        // Clock ratios
        repeat (4) @(negedge clk);
        check("reset_outputs", {57'd0, mclk, sclk, lrck, sdata, frame_start, underrun, s_ready}, 64'd0);
        rst = 1'b0;
        mr = 0; sr = 0; lr = 0; fs = 0; lh = 0; pm = 0; ps = 0; pl = 0;
        repeat (4096) begin
            @(posedge clk);
            #3;
            if (mclk && !pm) mr++;
            if (sclk && !ps) sr++;
            if (lrck && !pl) lr++;
            if (frame_start) fs++;
            if (lrck) lh++;
            pm = mclk; ps = sclk; pl = lrck;
        end
        check("mclk_rises", 64'(mr), 64'd512);
        check("sclk_rises", 64'(sr), 64'd128);
        check("lrck_rises", 64'(lr), 64'd2);
        check("frame_starts", 64'(fs), 64'd2);
        check("lrck_high_cycles", 64'(lh), 64'd2048);

        // Serialisation
        do_reset();
        en = 1'b1;
        send(24'hABCDEF, 24'h123456);
        wait_frames(3);
        check("ser_frame1_zero", fbits[1], 64'd0);
        check("ser_frame2", fbits[2], pat(24'hABCDEF, 24'h123456));
        check("ser_underruns", 64'(fur[1] + fur[2]), 64'd0);

        // Underrun after three streamed frames
        do_reset();
        send(24'h000001, 24'hFFFFFF);
        send(24'h7FFFFF, 24'h800000);
        send(24'h800001, 24'h7FFFFE);
        wait_frames(6);
        check("ur_frame2", fbits[2], pat(24'h000001, 24'hFFFFFF));
        check("ur_frame3", fbits[3], pat(24'h7FFFFF, 24'h800000));
        check("ur_frame4", fbits[4], pat(24'h800001, 24'h7FFFFE));
        check("ur_none_before", 64'(fur[2] + fur[3] + fur[4]), 64'd0);
        check("ur_pulse_count", 64'(fur[5]), 64'd1);
`ifdef I2S_TX_HOLD_LAST_EN
        check("ur_frame5_data", fbits[5], pat(24'h800001, 24'h7FFFFE));
`else
        check("ur_frame5_data", fbits[5], 64'd0);
`endif

        // Backpressure with a continuously valid, incrementing source
        do_reset();
        v = 24'd1;
        t = 0;
        while (frame_no < 6 && t < 20000) begin
            s_valid = 1'b1; s_left = v; s_right = ~v;
            rdy = s_ready;
            @(negedge clk);
            if (rdy) v++;
            t++;
        end
        s_valid = 1'b0;
        for (int f = 2; f <= 5; f++) begin
            check("bp_frame_data", fbits[f], pat(24'(f - 1), ~24'(f - 1)));
            check("bp_ready_windows", 64'(frr[f]), 64'd1);
            check("bp_no_underrun", 64'(fur[f]), 64'd0);
        end

        // Pair offered only in the boundary cycle while the holding register is empty
        t = 0;
        while (!(m_p == 0 && !m_full && m_run && en) && t < 10000) begin
            @(negedge clk);
            t++;
        end
        check("coll_setup", 64'(m_p == 0 && !m_full), 64'd1);
        tgt = frame_no + 1;
        s_valid = 1'b1; s_left = 24'h5A5A5A; s_right = 24'hA5A5A5;
        @(negedge clk);
        s_valid = 1'b0; s_left = '0; s_right = '0;
        wait_frames(tgt + 2);
        check("coll_underrun", 64'(fur[tgt]), 64'd1);
        check("coll_next_frame", fbits[tgt+1], pat(24'h5A5A5A, 24'hA5A5A5));
        check("coll_next_no_ur", 64'(fur[tgt+1]), 64'd0);

        // en dropped mid-frame, then restored
        do_reset();
        en = 1'b1;
        send(24'h0F0F0F, 24'hF0F0F0);
        wait_frames(2);
        send(24'h13579B, 24'h2468AC);
        wait_p(1000);
        en = 1'b0;
        wait_frames(4);
        wait_p(1000);
        en = 1'b1;
        wait_frames(6);
        check("en_frame2_completes", fbits[2], pat(24'h0F0F0F, 24'hF0F0F0));
        check("en_frame3_zero", fbits[3], 64'd0);
        check("en_frame4_zero", fbits[4], 64'd0);
        check("en_frame5_resume", fbits[5], pat(24'h13579B, 24'h2468AC));
        check("en_no_underrun", 64'(fur[2] + fur[3] + fur[4] + fur[5]), 64'd0);

        // Reset mid-frame
        wait_p(700);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rst_mid_outputs", {57'd0, mclk, sclk, lrck, sdata, frame_start, underrun, s_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("rst_restart_fs", {62'd0, frame_start, s_ready}, 64'd3);
        check("rst_restart_clks", {60'd0, mclk, sclk, lrck, underrun}, 64'd0);
        wait_frames(2);
        check("rst_frame1_zero", fbits[1], 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
